// File: rtl/aska_npg_pkg.sv
// aska_npg_pkg: shared types, config field layout and ramp amplitude helper for the multi-channel NPG.
package aska_npg_pkg;
  typedef enum logic [2:0] {IDLE, PH1, GAP, PH2, DEAD} arb_state_t;
  typedef enum logic {B_ON, B_OFF} burst_t;
  localparam logic [1:0] ADDR_CONF0 = 2'd0;
  localparam logic [1:0] ADDR_CONF1 = 2'd1;
  localparam logic [1:0] ADDR_ELE1  = 2'd2;
  localparam logic [1:0] ADDR_ELE2  = 2'd3;
  localparam int FREQ_LSB = 0;
  localparam int FREQ_W   = 12;
  localparam int AMPL_LSB = 12;
  localparam int AMPL_W   = 6;
  localparam int RAMP_LSB = 18;
  localparam int RAMP_W   = 6;
  localparam int ON_LSB   = 24;
  localparam int ON_W     = 8;
  localparam int RF_LSB   = 0;
  localparam int RF_W     = 10;
  localparam int OFF_LSB  = 10;
  localparam int OFF_W    = 10;
  localparam int EN_BIT   = 20;
  localparam int PD_LSB   = 21;
  localparam int PD_W     = 3;
  function automatic logic [5:0] amp_ramp(input logic [7:0] k, input logic [5:0] ramp,
                                          input logic [5:0] amp, input logic [9:0] rf);
    logic [17:0] p;
    p = ({10'd0, k} * {8'd0, rf}) >> 4;
    if (ramp == 6'd0 || k > {2'b00, ramp}) return amp;
    return (p < {12'd0, amp}) ? p[5:0] : amp;
  endfunction
endpackage

// File: rtl/aska_npg_chan.sv
// aska_npg_chan: one stimulation channel (config regs, period timer, burst FSM, ramp, pending request).
// ASKA_NPG_OVERRUN_EN adds a sticky flag for events dropped while a request is still pending.
module aska_npg_chan
  import aska_npg_pkg::*;
#(
  parameter int N_ELE = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  input  logic             grant,
  output logic             enable,
  output logic             pending,
  output logic [5:0]       amp,
  output logic [2:0]       ph,
  output logic [N_ELE-1:0] ele1,
  output logic [N_ELE-1:0] ele2,
  output logic             overrun
);
  logic [31:0] conf0;
  logic [23:0] conf1;
  logic [11:0] cnt;
  logic [9:0]  bcnt;
  logic [7:0]  k;
  burst_t      bst;
  logic [FREQ_W-1:0] freq;
  logic [AMPL_W-1:0] amplitude;
  logic [RAMP_W-1:0] ramp;
  logic [ON_W-1:0]   on_time;
  logic [RF_W-1:0]   rf;
  logic [OFF_W-1:0]  off_time;
  logic [PD_W-1:0]   pd;
  logic conf1_we, evt, on_evt;
  assign freq      = conf0[FREQ_LSB +: FREQ_W];
  assign amplitude = conf0[AMPL_LSB +: AMPL_W];
  assign ramp      = conf0[RAMP_LSB +: RAMP_W];
  assign on_time   = conf0[ON_LSB +: ON_W];
  assign rf        = conf1[RF_LSB +: RF_W];
  assign off_time  = conf1[OFF_LSB +: OFF_W];
  assign enable    = conf1[EN_BIT];
  assign pd        = conf1[PD_LSB +: PD_W];
  assign ph        = (pd == 3'd0) ? 3'd1 : pd;
  assign conf1_we  = we && addr == ADDR_CONF1;
  assign evt       = enable && freq != '0 && cnt == '0;
  assign on_evt    = evt && bst == B_ON;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      conf0 <= '0;
      conf1 <= '0;
      ele1  <= '0;
      ele2  <= '0;
    end else if (we) begin
      if (addr == ADDR_CONF0) conf0 <= wdata;
      if (addr == ADDR_CONF1) conf1 <= wdata[23:0];
      if (addr == ADDR_ELE1) ele1 <= wdata[N_ELE-1:0];
      if (addr == ADDR_ELE2) ele2 <= wdata[N_ELE-1:0];
    end

  // Disable or any conf1 write restarts the timer and re-enters ON with k=1.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt  <= '0;
      bcnt <= '0;
      k    <= 8'd1;
      bst  <= B_ON;
    end else if (!enable || conf1_we) begin
      cnt  <= '0;
      bcnt <= '0;
      k    <= 8'd1;
      bst  <= B_ON;
    end else if (evt) begin
      cnt <= freq - 12'd1;
      if (bst == B_ON) begin
        k <= (k == 8'hff) ? k : k + 8'd1;
        if (on_time != '0) begin
          if (bcnt + 10'd1 == {2'b00, on_time}) begin
            bcnt <= '0;
            if (off_time != '0) bst <= B_OFF;
            else k <= 8'd1;
          end else bcnt <= bcnt + 10'd1;
        end
      end else if (bcnt + 10'd1 == off_time) begin
        bcnt <= '0;
        bst  <= B_ON;
        k    <= 8'd1;
      end else bcnt <= bcnt + 10'd1;
    end else if (freq != '0) cnt <= cnt - 12'd1;

  // Amplitude is fixed when the request is raised so it matches the pulse index.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      pending <= 1'b0;
      amp     <= '0;
    end else if (!enable) pending <= 1'b0;
    else if (on_evt && !pending) begin
      pending <= 1'b1;
      amp     <= amp_ramp(k, ramp, amplitude, rf);
    end else if (grant) pending <= 1'b0;

`ifdef ASKA_NPG_OVERRUN_EN
  logic drop, ovr;
  assign drop    = on_evt && pending;
  assign overrun = ovr;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ovr <= 1'b0;
    else if (conf1_we) ovr <= 1'b0;
    else if (drop) ovr <= 1'b1;
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: rtl/aska_npg_multi.sv
// aska_npg_multi: N_CH stimulation channels sharing one H-bridge/DAC through a round-robin pulse arbiter.
// Define ASKA_NPG_OVERRUN_EN to enable the per-channel sticky overrun flags.
module aska_npg_multi
  import aska_npg_pkg::*;
#(
  parameter int  N_CH  = 4,
  parameter int  N_ELE = 32,
  parameter int  AMP_W = 6,
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [N_ELE-1:0] up_switches,
  output logic [N_ELE-1:0] down_switches,
  output logic [AMP_W-1:0] DAC,
  output logic             pulse_active,
  output logic [CW-1:0]    active_ch,
  output logic             enable_any,
  output logic [N_CH-1:0]  overrun
);
  arb_state_t state, nxt;
  logic [CW-1:0]    rr, gnt;
  logic [2:0]       tcnt, tn, s_ph;
  logic [5:0]       s_amp, n_amp;
  logic [N_ELE-1:0] s_e1, s_e2, n_e1, n_e2;
  logic [N_CH-1:0]  pend, en, grant_v;
  logic [5:0]       c_amp [N_CH];
  logic [2:0]       c_ph  [N_CH];
  logic [N_ELE-1:0] c_e1  [N_CH];
  logic [N_ELE-1:0] c_e2  [N_CH];
  logic found, take;
  int   idx;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    aska_npg_chan #(.N_ELE(N_ELE)) u_chan (
      .clk     (clk),
      .resetn  (resetn),
      .we      (cfg_we && cfg_ch == CW'(i)),
      .addr    (cfg_addr),
      .wdata   (cfg_wdata),
      .grant   (grant_v[i]),
      .enable  (en[i]),
      .pending (pend[i]),
      .amp     (c_amp[i]),
      .ph      (c_ph[i]),
      .ele1    (c_e1[i]),
      .ele2    (c_e2[i]),
      .overrun (overrun[i])
    );
  end

  assign enable_any   = |en;
  assign pulse_active = state == PH1 || state == GAP || state == PH2;

  // Granting from DEAD as well as IDLE keeps back-to-back pulses one tick apart.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int j = 0; j < N_CH; j++) begin
      idx = (int'(rr) + j) % N_CH;
      if (!found && pend[idx]) begin
        found = 1'b1;
        gnt   = CW'(idx);
      end
    end
    take    = found && (state == IDLE || state == DEAD);
    grant_v = take ? (N_CH'(1) << gnt) : '0;
    n_e1    = take ? c_e1[gnt] : s_e1;
    n_e2    = take ? c_e2[gnt] : s_e2;
    n_amp   = take ? c_amp[gnt] : s_amp;
    nxt     = state;
    tn      = tcnt;
    case (state)
      IDLE, DEAD: begin
        nxt = take ? PH1 : IDLE;
        tn  = take ? c_ph[gnt] - 3'd1 : 3'd0;
      end
      PH1: begin
        nxt = (tcnt == 3'd0) ? GAP : PH1;
        tn  = (tcnt == 3'd0) ? s_ph - 3'd1 : tcnt - 3'd1;
      end
      GAP: nxt = PH2;
      PH2: begin
        nxt = (tcnt == 3'd0) ? DEAD : PH2;
        tn  = (tcnt == 3'd0) ? 3'd0 : tcnt - 3'd1;
      end
      default: nxt = IDLE;
    endcase
  end

  // Overlapping electrodes are masked on the down side in both phases.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state         <= IDLE;
      rr            <= '0;
      tcnt          <= '0;
      s_ph          <= '0;
      s_amp         <= '0;
      s_e1          <= '0;
      s_e2          <= '0;
      active_ch     <= '0;
      up_switches   <= '0;
      down_switches <= '0;
      DAC           <= '0;
    end else begin
      state <= nxt;
      tcnt  <= tn;
      s_e1  <= n_e1;
      s_e2  <= n_e2;
      s_amp <= n_amp;
      if (take) begin
        s_ph      <= c_ph[gnt];
        rr        <= (gnt == CW'(N_CH - 1)) ? '0 : gnt + 1'b1;
        active_ch <= gnt;
      end
      up_switches   <= (nxt == PH1) ? n_e1 : (nxt == PH2) ? n_e2 : '0;
      down_switches <= (nxt == PH1) ? n_e2 & ~n_e1 : (nxt == PH2) ? n_e1 & ~n_e2 : '0;
      DAC           <= (nxt == PH1 || nxt == PH2) ? AMP_W'(n_amp) : '0;
    end
endmodule

// File: tb/tb_aska_npg_multi.sv
// tb_aska_npg_multi: directed scoreboard bench for aska_npg_multi (expected pulses queued at config time).
module tb_aska_npg_multi;
  logic        clk = 1'b0, resetn = 1'b0, cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0, cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] up_switches, down_switches;
  logic [5:0]  DAC;
  logic        pulse_active, enable_any;
  logic [1:0]  active_ch;
  logic [3:0]  overrun;

  typedef struct {int ch; logic [31:0] amp; logic [31:0] e1; logic [31:0] e2; int ph;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int   starts[$];
  int   cyc = 0, n_cmp = 0, n_err = 0, pos = 0;
  bit   busy = 1'b0, in1, in2;
  logic [31:0] e_up, e_dn, e_dac;

  aska_npg_multi #(.N_CH(4), .N_ELE(32), .AMP_W(6)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cfg_we        (cfg_we),
    .cfg_ch        (cfg_ch),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .up_switches   (up_switches),
    .down_switches (down_switches),
    .DAC           (DAC),
    .pulse_active  (pulse_active),
    .active_ch     (active_ch),
    .enable_any    (enable_any),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] c0(input int on, input int ramp, input int amp, input int freq);
    return {on[7:0], ramp[5:0], amp[5:0], freq[11:0]};
  endfunction

  function automatic logic [31:0] c1(input int pd, input int en, input int off, input int rf);
    return {8'd0, pd[2:0], en[0], off[9:0], rf[9:0]};
  endfunction

  task automatic wr(input int ch, input int a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_ch = ch[1:0];
    cfg_addr = a[1:0];
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic setup(input int ch, input int e1, input int e2, input logic [31:0] conf0);
    wr(ch, 2, e1);
    wr(ch, 3, e2);
    wr(ch, 0, conf0);
  endtask

  task automatic push(input int ch, input int amp, input int e1, input int e2, input int ph);
    exp_t e;
    e.ch = ch; e.amp = amp; e.e1 = e1; e.e2 = e2; e.ph = ph;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(sb.size()), 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (pulse_active && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(pulse_active), 0);
  endtask

  task automatic check_gaps(input string tag, input int d[$], input int total);
    chk({tag, "_count"}, 32'(starts.size()), 32'(total));
    for (int i = 0; i < d.size(); i++)
      if (i + 1 < starts.size()) chk(tag, 32'(starts[i+1] - starts[i]), 32'(d[i]));
  endtask

  // Pulse monitor: pops the scoreboard on each pulse start and checks every phase tick.
  always @(negedge clk) begin
    if (!resetn) busy = 1'b0;
    else begin
      if (pulse_active && !busy) begin
        chk("pulse_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) cur = sb.pop_front();
        starts.push_back(cyc);
        busy = 1'b1;
        pos = 0;
        chk("active_ch", 32'(active_ch), 32'(cur.ch));
      end
      if (busy) begin
        in1 = pos < cur.ph;
        in2 = pos > cur.ph && pos <= 2 * cur.ph;
        e_up = in1 ? cur.e1 : in2 ? cur.e2 : 32'd0;
        e_dn = in1 ? cur.e2 & ~cur.e1 : in2 ? cur.e1 & ~cur.e2 : 32'd0;
        e_dac = (in1 || in2) ? cur.amp : 32'd0;
        chk("up", up_switches, e_up);
        chk("down", down_switches, e_dn);
        chk("dac", 32'(DAC), e_dac);
        chk("pulse_active", 32'(pulse_active), 32'(pos <= 2 * cur.ph));
        if (pos == 2 * cur.ph + 1) busy = 1'b0;
        pos++;
      end
    end
  end

  initial begin
    #300000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_up", up_switches, 0);
    chk("rst_down", down_switches, 0);
    chk("rst_dac", 32'(DAC), 0);
    chk("rst_active", 32'(pulse_active), 0);
    chk("rst_ch", 32'(active_ch), 0);
    chk("rst_en", 32'(enable_any), 0);
    chk("rst_ovr", 32'(overrun), 0);
    resetn = 1'b1;
    // basic periodic pulse
    setup(0, 1, 2, c0(0, 0, 20, 400));
    starts.delete();
    push(0, 20, 1, 2, 2);
    push(0, 20, 1, 2, 2);
    wr(0, 1, c1(2, 1, 0, 0));
    wait_empty("t1_drain", 1000);
    chk("t1_enable_any", 32'(enable_any), 1);
    wait_idle("t1_idle");
    wr(0, 1, c1(2, 0, 0, 0));
    chk("t1_disable", 32'(enable_any), 0);
    check_gaps("t1_period", '{400}, 2);
    // ramp 8,16,24,32,32
    wr(0, 0, c0(0, 4, 32, 20));
    for (int i = 1; i <= 5; i++) push(0, (i < 4) ? 8 * i : 32, 1, 2, 1);
    wr(0, 1, c1(1, 1, 0, 128));
    wait_empty("t2_drain", 300);
    wait_idle("t2_idle");
    wr(0, 1, c1(1, 0, 0, 0));
    // burst ON=3 OFF=2
    wr(0, 0, c0(3, 0, 10, 10));
    starts.delete();
    repeat (6) push(0, 10, 1, 2, 1);
    wr(0, 1, c1(1, 1, 2, 0));
    wait_empty("t3_drain", 200);
    wait_idle("t3_idle");
    wr(0, 1, c1(1, 0, 0, 0));
    check_gaps("t3_burst", '{10, 10, 30, 10, 10}, 6);
    // four channels back to back, ch3 has an overlapping electrode
    for (int i = 0; i < 4; i++) setup(i, 1 << i, (1 << (i + 8)) | ((i == 3) ? 8 : 0), c0(0, 0, 10 + i, 100));
    starts.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) push(i, 10 + i, 1 << i, (1 << (i + 8)) | ((i == 3) ? 8 : 0), 2);
    for (int i = 0; i < 4; i++) wr(i, 1, c1(2, 1, 0, 0));
    wait_empty("t4_drain", 400);
    wait_idle("t4_idle");
    for (int i = 0; i < 4; i++) wr(i, 1, c1(2, 0, 0, 0));
    check_gaps("t4_b2b", '{6, 6, 6}, 8);
    // overrun: long pulses, short period
    setup(0, 'h10, 'h20, c0(0, 0, 5, 5));
    setup(1, 'h40, 'h80, c0(0, 0, 6, 5));
    push(0, 5, 'h10, 'h20, 7);
    push(1, 6, 'h40, 'h80, 7);
    push(0, 5, 'h10, 'h20, 7);
    push(1, 6, 'h40, 'h80, 7);
    wr(0, 1, c1(7, 1, 0, 0));
    wr(1, 1, c1(7, 1, 0, 0));
    wait_empty("t5_drain", 200);
`ifdef ASKA_NPG_OVERRUN_EN
    chk("t5_overrun", 32'(overrun), 32'h3);
`else
    chk("t5_overrun", 32'(overrun), 0);
`endif
    wr(0, 1, c1(7, 0, 0, 0));
    wr(1, 1, c1(7, 0, 0, 0));
    wait_idle("t5_idle");
    chk("t5_overrun_clr", 32'(overrun), 0);
    // enable cleared during PH1: pulse still completes
    setup(0, 3, 'hC, c0(0, 0, 12, 50));
    push(0, 12, 3, 'hC, 3);
    wr(0, 1, c1(3, 1, 0, 0));
    wait_empty("t6a_drain", 100);
    wr(0, 1, c1(3, 0, 0, 0));
    wait_idle("t6a_idle");
    repeat (80) @(negedge clk);
    chk("t6a_enable_any", 32'(enable_any), 0);
    // reset during PH1: outputs drop immediately
    wr(0, 1, c1(3, 1, 0, 0));
    push(0, 12, 3, 'hC, 3);
    wait_empty("t6b_drain", 100);
    chk("t6b_in_pulse", 32'(pulse_active), 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6b_up", up_switches, 0);
    chk("t6b_down", down_switches, 0);
    chk("t6b_dac", 32'(DAC), 0);
    chk("t6b_active", 32'(pulse_active), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (60) @(negedge clk);
    chk("t6b_en", 32'(enable_any), 0);
    chk("t6b_ovr", 32'(overrun), 0);
    chk("t6b_quiet", 32'(pulse_active), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
